// File: rtl/key_schedule.sv
// AES key expansion for 128/192/256-bit keys.
// Words are generated one per two cycles into a word store read by round.
module key_schedule #(
  parameter int WORD_LEN    = 32,
  parameter int MAX_KEY_LEN = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             key_len_sel,
  input  logic [MAX_KEY_LEN-1:0] key_in,
  input  logic                   rk_rd_en,
  input  logic [3:0]             rk_rd_addr,
  output logic [127:0]           rk_rd_data,
  output logic                   rk_rd_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [3:0]             num_rounds
);

  typedef logic [WORD_LEN-1:0] word_t;
  typedef enum logic [1:0] {IDLE, LOAD, SUB, WR} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254, then the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  nk_q;
  logic [3:0]  nr_q;
  logic [255:0] key_q;
  logic [5:0]  idx_q;
  logic [2:0]  mod_q;
  word_t       temp_q;
  word_t       temp_d;
  word_t       wnew;
  logic [7:0]  rcon_q;
  logic        keys_valid;
  logic        last;
  logic        sel_ok;
  logic [3:0]  sel_nk;
  logic [3:0]  sel_nr;
  logic [5:0]  rk_base;
  logic [127:0] rk_word;
  word_t       wmem [64];

  // Key size decode.
  always_comb begin
    sel_ok = 1'b1;
    sel_nk = 4'd4;
    sel_nr = 4'd10;
    unique case (key_len_sel)
      2'd0: begin sel_nk = 4'd4; sel_nr = 4'd10; end
      2'd1: begin sel_nk = 4'd6; sel_nr = 4'd12; end
      2'd2: begin sel_nk = 4'd8; sel_nr = 4'd14; end
      default: sel_ok = 1'b0;
    endcase
  end

  // Word generation datapath and round-key gather.
  always_comb begin
    word_t prev;
    prev = wmem[idx_q - 6'd1];
    last = (idx_q == ({nr_q, 2'b00} + 6'd3));
    if (mod_q == 3'd0)
      temp_d = sub_word({prev[23:0], prev[31:24]});
    else if (nk_q == 4'd8 && mod_q == 3'd4)
      temp_d = sub_word(prev);
    else
      temp_d = prev;
    wnew = wmem[idx_q - {2'b00, nk_q}] ^ temp_q
         ^ ((mod_q == 3'd0) ? {rcon_q, 24'h0} : 32'h0);
    rk_base = {rk_rd_addr, 2'b00};
    rk_word = {wmem[rk_base], wmem[rk_base + 6'd1],
               wmem[rk_base + 6'd2], wmem[rk_base + 6'd3]};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && sel_ok) state_d = LOAD;
      LOAD: state_d = SUB;
      SUB:  state_d = WR;
      WR:   state_d = last ? IDLE : SUB;
      default: state_d = IDLE;
    endcase
  end

  // Control state, counters and read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      nk_q        <= '0;
      nr_q        <= '0;
      key_q       <= '0;
      idx_q       <= '0;
      mod_q       <= '0;
      temp_q      <= '0;
      rcon_q      <= '0;
      keys_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      num_rounds  <= '0;
      rk_rd_valid <= 1'b0;
      rk_rd_data  <= '0;
    end else begin
      state_q     <= state_d;
      done        <= 1'b0;
      err         <= 1'b0;
      rk_rd_valid <= rk_rd_en;
      rk_rd_data  <= (rk_rd_en && keys_valid && rk_rd_addr <= num_rounds)
                   ? rk_word : 128'h0;
      unique case (state_q)
        IDLE: begin
          if (start && sel_ok) begin
            nk_q       <= sel_nk;
            nr_q       <= sel_nr;
            key_q      <= key_in;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            rcon_q     <= 8'h01;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          idx_q <= {2'b00, nk_q};
          mod_q <= 3'd0;
        end
        SUB: temp_q <= temp_d;
        WR: begin
          if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
          idx_q <= idx_q + 6'd1;
          mod_q <= ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
          if (last) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
            num_rounds <= nr_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Word store: initial key words in LOAD, one expanded word per WR.
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      for (int j = 0; j < 8; j++)
        if (4'(j) < nk_q) wmem[j] <= key_q[255-32*j -: 32];
    end else if (state_q == WR) begin
      wmem[idx_q] <= wnew;
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule using FIPS-197 appendix A vectors.
// Checks latency, round keys, illegal size, ignored start and mid-run reset.
module tb_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   key_len_sel;
  logic [255:0] key_in;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_addr;
  logic [127:0] rk_rd_data;
  logic         rk_rd_valid;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   num_rounds;

  int total  = 0;
  int passed = 0;
  int n;

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef0123456789abcdef55aa55aa};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_schedule #(.WORD_LEN(32), .MAX_KEY_LEN(256)) dut (
    .clk(clk), .reset(reset), .start(start), .key_len_sel(key_len_sel),
    .key_in(key_in), .rk_rd_en(rk_rd_en), .rk_rd_addr(rk_rd_addr),
    .rk_rd_data(rk_rd_data), .rk_rd_valid(rk_rd_valid), .busy(busy),
    .done(done), .err(err), .num_rounds(num_rounds)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a,
                        input logic [127:0] exp);
    rk_rd_en   = 1'b1;
    rk_rd_addr = a;
    tick();
    rk_rd_en = 1'b0;
    chk({tag, "_v"}, 128'(rk_rd_valid), 128'd1);
    chk(tag, rk_rd_data, exp);
  endtask

  task automatic launch(input logic [1:0] sel, input logic [255:0] key);
    start       = 1'b1;
    key_len_sel = sel;
    key_in      = key;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!done && cnt < 300);
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    key_len_sel = 2'd0;
    key_in      = '0;
    rk_rd_en    = 1'b0;
    rk_rd_addr  = 4'd0;
    repeat (3) tick();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_nr", 128'(num_rounds), 128'd0);
    chk("rst_valid", 128'(rk_rd_valid), 128'd0);
    chk("rst_data", rk_rd_data, 128'h0);
    reset = 1'b1;
    tick();
    rd_chk("pre_rd", 4'd0, 128'h0);

    // AES-128 with an ignored start and a busy read at cycle 20
    launch(2'd0, K128);
    chk("a128_busy", 128'(busy), 128'd1);
    repeat (19) tick();
    start       = 1'b1;
    key_len_sel = 2'd2;
    key_in      = K256;
    rk_rd_en    = 1'b1;
    rk_rd_addr  = 4'd0;
    tick();
    start    = 1'b0;
    rk_rd_en = 1'b0;
    chk("busy_rd_v", 128'(rk_rd_valid), 128'd1);
    chk("busy_rd", rk_rd_data, 128'h0);
    wait_done(n);
    chk("a128_lat", 128'(20 + n), 128'd81);
    chk("a128_nr", 128'(num_rounds), 128'd10);
    tick();
    chk("done_pulse", 128'(done), 128'd0);
    chk("busy_off", 128'(busy), 128'd0);
    rd_chk("a128_r0", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd_chk("a128_r1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_chk("a128_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_chk("a128_r11", 4'd11, 128'h0);

    // Illegal key size
    start       = 1'b1;
    key_len_sel = 2'd3;
    tick();
    start = 1'b0;
    chk("err_hi", 128'(err), 128'd1);
    chk("err_busy", 128'(busy), 128'd0);
    tick();
    chk("err_lo", 128'(err), 128'd0);
    chk("err_nr", 128'(num_rounds), 128'd10);
    rd_chk("err_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-192
    launch(2'd1, K192);
    wait_done(n);
    chk("a192_lat", 128'(n), 128'd93);
    chk("a192_nr", 128'(num_rounds), 128'd12);
    rd_chk("a192_r0", 4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
    rk_rd_en   = 1'b1;
    rk_rd_addr = 4'd12;
    tick();
    rk_rd_en = 1'b0;
    chk("a192_r12_v", 128'(rk_rd_valid), 128'd1);
    chk("a192_r12", 128'(rk_rd_data[31:0]), 128'h01002202);
    rd_chk("a192_r13", 4'd13, 128'h0);

    // AES-256
    launch(2'd2, K256);
    wait_done(n);
    chk("a256_lat", 128'(n), 128'd105);
    chk("a256_nr", 128'(num_rounds), 128'd14);
    rd_chk("a256_r0", 4'd0, 128'h603deb1015ca71be2b73aef0857d7781);
    rd_chk("a256_r14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    rd_chk("a256_r15", 4'd15, 128'h0);

    // Reset at cycle 40 of an AES-256 run
    launch(2'd2, K256);
    repeat (39) tick();
    reset = 1'b0;
    #2;
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_nr", 128'(num_rounds), 128'd0);
    tick();
    reset = 1'b1;
    tick();
    rd_chk("mid_rst_r0", 4'd0, 128'h0);

    // Fresh AES-128 after the abandoned run
    launch(2'd0, K128);
    wait_done(n);
    chk("re128_lat", 128'(n), 128'd81);
    rd_chk("re128_r1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_chk("re128_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
